// File: rtl/audio_ram_scheduler.sv
// Audio RAM scheduler: shares one DDR2 user port between record writes and playback reads.
// Latency: request to RAM strobe 2 cycles; rd_rd_data_pres to rd_valid 1 cycle; reads time out after READ_TIMEOUT cycles.
// Backpressure: ram_rdy low only holds off new grants; wr_req on a full or pending slot raises wr_overrun.
// Optional: define AUDIO_RAM_LOOP_EN for looped playback (rd_ptr wraps at max_address, play_done never set).
module audio_ram_scheduler #(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 16,
    parameter int READ_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_en,
    input  logic              play_en,
    input  logic              addr_clear,
    input  logic [ADDR_W-1:0] max_address,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_overrun,
    output logic              rd_timeout,
    output logic              rec_full,
    output logic              play_done,
    input  logic              ram_rdy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_request,
    output logic              ram_read_ack,
    input  logic              ram_rd_data_pres,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_WAIT} state_t;

    // Timeout fires on the last of READ_TIMEOUT waiting cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(READ_TIMEOUT - 1);

    state_t            state;
    logic              wr_pend;
    logic              rd_pend;
    logic [DATA_W-1:0] wr_lat;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              last_grant_rd;
    logic [7:0]        wait_cnt;

    logic wr_ok;
    logic rd_ok;
    logic idle_ok;
    logic grant_wr;
    logic grant_rd;
    logic wr_fire;
    logic rd_fire;

    // A pending request that raced with the end-of-range flag is never served.
    assign wr_ok    = wr_pend & ~rec_full;
    assign rd_ok    = rd_pend & ~play_done;
    assign idle_ok  = (state == IDLE) & ram_rdy;
    // Contested grants alternate; last_grant only moves on a contested decision.
    assign grant_wr = idle_ok & wr_ok & (~rd_ok | last_grant_rd);
    assign grant_rd = idle_ok & rd_ok & ~grant_wr;
    assign wr_fire  = wr_req & rec_en;
    assign rd_fire  = rd_req & play_en & ~play_done & ~rd_pend;
    assign busy     = (state != IDLE);

    // Scheduler FSM, request capture, pointer bookkeeping and registered RAM strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            wr_pend          <= 1'b0;
            rd_pend          <= 1'b0;
            wr_lat           <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            last_grant_rd    <= 1'b1;
            wait_cnt         <= '0;
            rd_data          <= '0;
            rd_valid         <= 1'b0;
            wr_overrun       <= 1'b0;
            rd_timeout       <= 1'b0;
            rec_full         <= 1'b0;
            play_done        <= 1'b0;
            ram_addr         <= '0;
            ram_data_in      <= '0;
            ram_write_enable <= 1'b0;
            ram_read_request <= 1'b0;
            ram_read_ack     <= 1'b0;
        end else begin
            ram_write_enable <= 1'b0;
            ram_read_request <= 1'b0;
            ram_read_ack     <= 1'b0;
            rd_valid         <= 1'b0;
            wr_overrun       <= 1'b0;
            rd_timeout       <= 1'b0;

            case (state)
                IDLE: begin
                    if (wr_pend && rec_full) wr_pend <= 1'b0;
                    if (rd_pend && play_done) rd_pend <= 1'b0;
                    if (grant_wr) begin
                        // Bookkeeping happens at grant so a same-cycle wr_req can queue behind it.
                        state            <= WRITE;
                        ram_write_enable <= 1'b1;
                        ram_addr         <= wr_ptr;
                        ram_data_in      <= wr_lat;
                        wr_pend          <= 1'b0;
                        if (wr_ptr == max_address) rec_full <= 1'b1;
                        else                       wr_ptr   <= wr_ptr + ADDR_W'(1);
                    end else if (grant_rd) begin
                        state            <= READ_REQ;
                        ram_read_request <= 1'b1;
                        ram_addr         <= rd_ptr;
                        rd_pend          <= 1'b0;
                    end
                    if (wr_ok && rd_ok && ram_rdy) last_grant_rd <= grant_rd;
                end
                WRITE: state <= IDLE;
                READ_REQ: begin
                    state    <= READ_WAIT;
                    wait_cnt <= '0;
                end
                READ_WAIT: begin
                    if (ram_rd_data_pres) begin
                        rd_data      <= ram_data_out;
                        rd_valid     <= 1'b1;
                        ram_read_ack <= 1'b1;
                        state        <= IDLE;
                        if (rd_ptr == max_address) begin
`ifdef AUDIO_RAM_LOOP_EN
                            rd_ptr <= '0;
`else
                            play_done <= 1'b1;
`endif
                        end else begin
                            rd_ptr <= rd_ptr + ADDR_W'(1);
                        end
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        // Give the codec a silent sample and leave the pointer for a retry.
                        rd_data    <= '0;
                        rd_valid   <= 1'b1;
                        rd_timeout <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Capture after the grant so a new request survives the grant clearing its flag.
            if (wr_fire) begin
                if (rec_full) begin
                    wr_overrun <= 1'b1;
                end else begin
                    wr_lat  <= wr_data;
                    wr_pend <= 1'b1;
                    if (wr_pend && !grant_wr) wr_overrun <= 1'b1;
                end
            end
            if (rd_fire) rd_pend <= 1'b1;

            // Clear overrides any pointer step taken in the same cycle.
            if (addr_clear) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                rec_full  <= 1'b0;
                play_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_ram_scheduler.sv
// Bench for audio_ram_scheduler: directed stimulus with expected RAM/codec events queued ahead.
// A monitor on the falling edge pops one expectation per observed event.
// A small RAM responder answers read requests after a programmable delay.
module tb_audio_ram_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        rec_en, play_en, addr_clear;
    logic [25:0] max_address;
    logic        wr_req;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        rd_valid, wr_overrun, rd_timeout, rec_full, play_done;
    logic        ram_rdy;
    logic [25:0] ram_addr;
    logic [15:0] ram_data_in;
    logic        ram_write_enable, ram_read_request, ram_read_ack;
    logic        ram_rd_data_pres;
    logic [15:0] ram_data_out;
    logic        busy;

    audio_ram_scheduler dut (
        .clk(clk), .reset(reset), .rec_en(rec_en), .play_en(play_en),
        .addr_clear(addr_clear), .max_address(max_address),
        .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_overrun(wr_overrun),
        .rd_timeout(rd_timeout), .rec_full(rec_full), .play_done(play_done),
        .ram_rdy(ram_rdy), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_write_enable(ram_write_enable), .ram_read_request(ram_read_request),
        .ram_read_ack(ram_read_ack), .ram_rd_data_pres(ram_rd_data_pres),
        .ram_data_out(ram_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // kind: 0 write strobe, 1 read request, 2 read result, 3 overrun
    typedef struct packed {
        logic [1:0]  kind;
        logic [25:0] addr;
        logic [15:0] data;
        logic        vld;
        logic        to;
        logic        ack;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    bit        rsp_en    = 1'b1;
    int        rsp_delay = 1;
    logic [15:0] rsp_data = 16'h0;

    function automatic ev_t mk(input logic [1:0] k, input logic [25:0] a, input logic [15:0] d,
                               input logic v, input logic t, input logic ak);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.vld = v; e.to = t; e.ack = ak;
        return e;
    endfunction

    function automatic void exp_w(input logic [25:0] a, input logic [15:0] d);
        exp_q.push_back(mk(2'd0, a, d, 1'b0, 1'b0, 1'b0));
    endfunction
    function automatic void exp_r(input logic [25:0] a);
        exp_q.push_back(mk(2'd1, a, 16'h0, 1'b0, 1'b0, 1'b0));
    endfunction
    function automatic void exp_v(input logic [15:0] d, input logic t);
        exp_q.push_back(mk(2'd2, 26'h0, d, 1'b1, t, ~t));
    endfunction
    function automatic void exp_o();
        exp_q.push_back(mk(2'd3, 26'h0, 16'h0, 1'b0, 1'b0, 1'b0));
    endfunction

    task automatic got(input string name, input ev_t act);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event actual=%h required=none", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e != act) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h (kind/addr/data/vld/to/ack)", name, act, e);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_wr(input logic [15:0] d);
        wr_req = 1'b1; wr_data = d;
        tick(1);
        wr_req = 1'b0;
    endtask

    task automatic do_rd();
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
    endtask

    task automatic pulse_clear();
        addr_clear = 1'b1;
        tick(1);
        addr_clear = 1'b0;
    endtask

    // Monitor: every observed strobe consumes one queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (ram_write_enable)
                got("write", mk(2'd0, ram_addr, ram_data_in, 1'b0, 1'b0, 1'b0));
            if (ram_read_request)
                got("read_req", mk(2'd1, ram_addr, 16'h0, 1'b0, 1'b0, 1'b0));
            if (rd_valid || ram_read_ack || rd_timeout)
                got("read_result", mk(2'd2, 26'h0, rd_data, rd_valid, rd_timeout, ram_read_ack));
            if (wr_overrun)
                got("overrun", mk(2'd3, 26'h0, 16'h0, 1'b0, 1'b0, 1'b0));
        end
    end

    // RAM responder: returns rsp_data rsp_delay cycles after a read request.
    initial begin
        ram_rd_data_pres = 1'b0;
        ram_data_out     = 16'h0;
        forever begin
            @(negedge clk);
            if (ram_read_request && rsp_en) begin
                repeat (rsp_delay) @(negedge clk);
                ram_rd_data_pres = 1'b1;
                ram_data_out     = rsp_data;
                @(negedge clk);
                ram_rd_data_pres = 1'b0;
            end
        end
    end

    initial begin
        reset = 1'b1; rec_en = 1'b1; play_en = 1'b1; addr_clear = 1'b0;
        max_address = 26'd3; wr_req = 1'b0; wr_data = 16'h0; rd_req = 1'b0; ram_rdy = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_strobes", {27'h0, rd_valid, ram_write_enable, ram_read_request, ram_read_ack, wr_overrun}, 32'h0);
        check("rst_flags", {29'h0, rec_full, play_done, rd_timeout}, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);

        // Record into a 4-word range; the fifth sample overruns
        for (int i = 0; i < 4; i++) begin
            exp_w(26'(i), 16'(16'h1111 * (i + 1)));
            do_wr(16'(16'h1111 * (i + 1)));
            tick(9);
        end
        check("rec_full_after_4", 32'(rec_full), 32'h1);
        exp_o();
        do_wr(16'h5555);
        tick(9);
        check("rec_full_held", 32'(rec_full), 32'h1);
        pulse_clear();
        tick(1);
        check("rec_full_cleared", 32'(rec_full), 32'h0);

        // Back-to-back samples while RAM is not ready: second overwrites and overruns
        max_address = 26'd15;
        ram_rdy = 1'b0;
        exp_o();
        exp_w(26'd0, 16'h7777);
        wr_req = 1'b1; wr_data = 16'h6666; tick(1);
        wr_data = 16'h7777; tick(1);
        wr_req = 1'b0;
        tick(3);
        check("busy_blocked", 32'(busy), 32'h0);
        ram_rdy = 1'b1;
        tick(5);

        // Contested requests: write first, then read wins the next contest
        rsp_delay = 2; rsp_data = 16'h1234;
        exp_w(26'd1, 16'hA0A0); exp_r(26'd0); exp_v(16'h1234, 1'b0);
        wr_req = 1'b1; wr_data = 16'hA0A0; rd_req = 1'b1; tick(1);
        wr_req = 1'b0; rd_req = 1'b0;
        tick(15);
        rsp_data = 16'h5678;
        exp_r(26'd1); exp_v(16'h5678, 1'b0); exp_w(26'd2, 16'hB0B0);
        wr_req = 1'b1; wr_data = 16'hB0B0; rd_req = 1'b1; tick(1);
        wr_req = 1'b0; rd_req = 1'b0;
        tick(15);

        // Read answered after 5 cycles
        rsp_delay = 5; rsp_data = 16'hBEEF;
        exp_r(26'd2); exp_v(16'hBEEF, 1'b0);
        do_rd();
        tick(12);
        check("rd_data_beef", 32'(rd_data), 32'hBEEF);

        // No answer: timeout returns zero and the pointer stays put
        rsp_en = 1'b0;
        exp_r(26'd3); exp_v(16'h0, 1'b1);
        do_rd();
        tick(270);
        check("timeout_rd_data", 32'(rd_data), 32'h0);
        rsp_en = 1'b1; rsp_delay = 1; rsp_data = 16'hCAFE;
        exp_r(26'd3); exp_v(16'hCAFE, 1'b0);
        do_rd();
        tick(8);
        check("rd_data_held", 32'(rd_data), 32'hCAFE);

        // End of playback range
        pulse_clear();
        max_address = 26'd1;
`ifdef AUDIO_RAM_LOOP_EN
        exp_r(26'd0); exp_v(16'h0D00, 1'b0);
        exp_r(26'd1); exp_v(16'h0D01, 1'b0);
        exp_r(26'd0); exp_v(16'h0D02, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rsp_data = 16'(16'h0D00 + i);
            do_rd();
            tick(10);
        end
        check("play_done_loop", 32'(play_done), 32'h0);
        check("loop_last_data", 32'(rd_data), 32'h0D02);
`else
        exp_r(26'd0); exp_v(16'h0D00, 1'b0);
        exp_r(26'd1); exp_v(16'h0D01, 1'b0);
        for (int i = 0; i < 2; i++) begin
            rsp_data = 16'(16'h0D00 + i);
            do_rd();
            tick(10);
        end
        check("play_done_set", 32'(play_done), 32'h1);
        rsp_data = 16'h0D02;
        do_rd();
        tick(10);
        check("play_done_held", 32'(play_done), 32'h1);
        check("dropped_read_data", 32'(rd_data), 32'h0D01);
`endif

        // Reset while waiting on read data
        pulse_clear();
        max_address = 26'd15;
        rsp_delay = 1; rsp_data = 16'h0E00;
        exp_r(26'd0); exp_v(16'h0E00, 1'b0);
        do_rd();
        tick(8);
        rsp_en = 1'b0;
        exp_r(26'd1);
        do_rd();
        tick(6);
        check("busy_in_wait", 32'(busy), 32'h1);
        reset = 1'b1;
        tick(1);
        check("midrst_strobes", {27'h0, rd_valid, ram_write_enable, ram_read_request, ram_read_ack, rd_timeout}, 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_rd_data", 32'(rd_data), 32'h0);
        reset = 1'b0;
        rsp_en = 1'b1; rsp_data = 16'h0E01;
        exp_r(26'd0); exp_v(16'h0E01, 1'b0);
        tick(1);
        do_rd();
        tick(8);

        check("events_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
